// File: rtl/rc_pkg.sv
// Shared types and default timing constants for the RC receiver capture blocks.
package rc_pkg;

  // 50 ms and 0.5 ms at a 100 MHz capture clock
  localparam int unsigned RC_TIMEOUT_CYC  = 5_000_000;
  localparam int unsigned RC_MIN_HIGH_CYC = 50_000;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } rc_cap_state_e;

endpackage

// File: rtl/sync_level.sv
// Level synchronizer with registered edge strobes for an asynchronous input pin.
// Ports:
//   clk_i   capture clock
//   rstn_i  asynchronous active-low reset
//   d_i     asynchronous input level
//   rise_o  one-cycle strobe on a synchronized 0->1 transition
//   fall_o  one-cycle strobe on a synchronized 1->0 transition
module sync_level #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              s_d_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronizer chain, one-cycle-delayed copy and edge strobes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      s_d_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~s_d_q;
      fall_q <= ~sync_q[STAGES-1] & s_d_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/rc_pwm_capture.sv
// Measures high time and rise-to-rise period of one RC servo PWM channel.
// Optional glitch filter: define RC_PWM_CAP_GLITCH_EN to reject high pulses
// shorter than MIN_HIGH_CYC.
// Ports:
//   clk_i      capture clock
//   rstn_i     asynchronous active-low reset
//   en_i       capture enable
//   pwm_i      asynchronous PWM input from the receiver pin
//   high_o     last accepted high time in cycles
//   period_o   last accepted rise-to-rise period in cycles
//   valid_o    one-cycle strobe, high_o/period_o updated
//   timeout_o  no rising edge for TIMEOUT_CYC cycles
module rc_pwm_capture
  import rc_pkg::*;
#(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TIMEOUT_CYC  = RC_TIMEOUT_CYC,
  parameter int unsigned MIN_HIGH_CYC = RC_MIN_HIGH_CYC
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  rc_cap_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             sync_rise, sync_fall;
  logic             timed_out_c;
  logic             glitch_c;

  sync_level #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pwm_i),
    .rise_o (sync_rise),
    .fall_o (sync_fall)
  );

  assign timed_out_c = (cnt_q >= TIMEOUT_LIM);

`ifdef RC_PWM_CAP_GLITCH_EN
  assign glitch_c = (cnt_q < CNT_W'(MIN_HIGH_CYC));
`else
  logic unused_min_c;
  assign glitch_c     = 1'b0;
  assign unused_min_c = ^CNT_W'(MIN_HIGH_CYC);
`endif

  // Cycle counter: restarts at 1 on every rise, parked at 0 while idle
  always_comb begin
    cnt_d = cnt_q;
    if (sync_rise) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == CAP_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Capture FSM next state and output updates
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    high_d    = high_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en_i) begin
      state_d = CAP_IDLE;
    end else begin
      unique case (state_q)
        CAP_IDLE: begin
          if (sync_rise) state_d = CAP_HIGH;
        end
        CAP_HIGH: begin
          if (sync_fall) begin
            if (glitch_c) begin
              state_d = CAP_IDLE;
            end else begin
              state_d  = CAP_LOW;
              shadow_d = cnt_q;
            end
          end else if (timed_out_c) begin
            state_d   = CAP_IDLE;
            timeout_d = 1'b1;
          end
        end
        CAP_LOW: begin
          // A rise in the timeout cycle still completes the frame
          if (sync_rise) begin
            state_d   = CAP_HIGH;
            high_d    = shadow_q;
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
          end else if (timed_out_c) begin
            state_d   = CAP_IDLE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= CAP_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      high_q    <= high_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign high_o    = high_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Scoreboard bench for rc_pwm_capture: pulse-level reference model feeds
// expected frames and timeout events; a negedge monitor checks the DUT.
module tb_rc_pwm_capture;

  localparam int unsigned CNT_W        = 24;
  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned TIMEOUT_CYC  = 5000;
  localparam int unsigned MIN_HIGH_CYC = 50;
  localparam int unsigned LAT          = SYNC_STAGES + 2;

  typedef struct {
    longint unsigned high;
    longint unsigned period;
    longint unsigned at;
  } frame_t;

  logic             clk_i;
  logic             rstn_i;
  logic             en_i;
  logic             pwm_i;
  logic [CNT_W-1:0] high_o;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             timeout_o;

  longint unsigned cyc = 0;
  int unsigned     n_checks = 0;
  int unsigned     n_pass = 0;

  // Reference model state (pulse level)
  bit              open;
  bit              to_lvl;
  longint unsigned prev_rise;
  longint unsigned prev_high;
  frame_t          vq[$];
  longint unsigned tq[$];

  rc_pwm_capture #(
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .MIN_HIGH_CYC (MIN_HIGH_CYC)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .en_i      (en_i),
    .pwm_i     (pwm_i),
    .high_o    (high_o),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    repeat (150000) @(posedge clk_i);
    $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Rising edge of pwm_i: completes the open frame, starts a new one
  task automatic rise_edge();
    frame_t f;
    pwm_i = 1'b1;
    if (open) begin
      f.high   = prev_high;
      f.period = cyc - prev_rise;
      f.at     = cyc + LAT;
      vq.push_back(f);
      to_lvl = 1'b0;
    end
    if (en_i) begin
      open      = 1'b1;
      prev_rise = cyc;
    end
  endtask

  // Falling edge of pwm_i; lo is the low time before the next rise
  task automatic fall_edge(input int unsigned hi, input int unsigned lo);
    pwm_i = 1'b0;
`ifdef RC_PWM_CAP_GLITCH_EN
    if (open && hi < MIN_HIGH_CYC) open = 1'b0;
`endif
    if (open) begin
      prev_high = hi;
      if (cyc + lo - prev_rise > TIMEOUT_CYC) begin
        if (!to_lvl) tq.push_back(prev_rise + TIMEOUT_CYC + LAT);
        to_lvl = 1'b1;
        open   = 1'b0;
      end
    end
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    rise_edge();
    repeat (hi) @(negedge clk_i);
    fall_edge(hi, lo);
    repeat (lo) @(negedge clk_i);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk_i) begin : mon
    frame_t          f;
    longint unsigned t;
    longint unsigned cur_high;
    longint unsigned cur_period;
    bit              prev_valid;
    bit              prev_to;
    if (!rstn_i) begin
      cur_high   = 0;
      cur_period = 0;
      prev_valid = 1'b0;
      prev_to    = 1'b0;
    end else begin
      if (timeout_o && !prev_to) begin
        chk("timeout_expected", longint'(tq.size() != 0), 1);
        if (tq.size() != 0) begin
          t = tq.pop_front();
          chk("timeout_rise_cycle", cyc, t);
        end
      end
      if (!timeout_o && prev_to) chk("timeout_clear_with_valid", longint'(valid_o), 1);
      if (valid_o) begin
        chk("valid_width", longint'(prev_valid), 0);
        chk("timeout_cleared", longint'(timeout_o), 0);
        chk("valid_expected", longint'(vq.size() != 0), 1);
        if (vq.size() != 0) begin
          f = vq.pop_front();
          chk("high", longint'(high_o), f.high);
          chk("period", longint'(period_o), f.period);
          chk("valid_cycle", cyc, f.at);
          cur_high   = f.high;
          cur_period = f.period;
        end
      end else begin
        chk("high_hold", longint'(high_o), cur_high);
        chk("period_hold", longint'(period_o), cur_period);
      end
      prev_valid = valid_o;
      prev_to    = timeout_o;
    end
  end

  initial begin
    int unsigned hi;
    int unsigned lo;
    int unsigned n_long;
    rstn_i    = 1'b0;
    en_i      = 1'b1;
    pwm_i     = 1'b0;
    open      = 1'b0;
    to_lvl    = 1'b0;
    prev_rise = 0;
    prev_high = 0;
    n_long    = 0;
    repeat (5) @(negedge clk_i);
    chk("reset_high", longint'(high_o), 0);
    chk("reset_period", longint'(period_o), 0);
    chk("reset_valid", longint'(valid_o), 0);
    chk("reset_timeout", longint'(timeout_o), 0);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Steady frames
    repeat (4) pulse(150, 850);

    // Long low gap, then recovery
    pulse(150, 6000);
    repeat (2) pulse(150, 850);

    // Gap exactly at the timeout limit, then one cycle over
    pulse(150, TIMEOUT_CYC - 150);
    pulse(150, TIMEOUT_CYC - 149);
    repeat (2) pulse(150, 850);

    // Enable dropped mid-high
    rise_edge();
    repeat (50) @(negedge clk_i);
    en_i = 1'b0;
    open = 1'b0;
    repeat (100) @(negedge clk_i);
    fall_edge(150, 850);
    repeat (300) @(negedge clk_i);
    en_i = 1'b1;
    repeat (550) @(negedge clk_i);
    repeat (3) pulse(150, 850);

    // Short glitch pulse between good frames
    pulse(150, 350);
    pulse(20, 480);
    repeat (3) pulse(150, 850);

    // Asynchronous reset in the low phase
    rise_edge();
    repeat (150) @(negedge clk_i);
    fall_edge(150, 850);
    repeat (300) @(negedge clk_i);
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_rst_high", longint'(high_o), 0);
    chk("async_rst_period", longint'(period_o), 0);
    chk("async_rst_valid", longint'(valid_o), 0);
    chk("async_rst_timeout", longint'(timeout_o), 0);
    open   = 1'b0;
    to_lvl = 1'b0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (550) @(negedge clk_i);
    repeat (3) pulse(150, 850);

    // Randomized pulse train
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(5, 0) == 0) hi = $urandom_range(40, 5);
      else hi = $urandom_range(400, 60);
      if (n_long < 3 && $urandom_range(7, 0) == 0) begin
        lo = $urandom_range(5600, 4700);
        n_long++;
      end else begin
        lo = $urandom_range(700, 200);
      end
      pulse(hi, lo);
    end

    repeat (50) @(negedge clk_i);
    chk("valid_queue_drained", longint'(vq.size()), 0);
    chk("timeout_queue_drained", longint'(tq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
